stream_arb_mux: RTL
===================

// Module: stream_arb_mux
// PURPOSE
//  Successor to the fixed 4-to-1 32-bit select mux: N-channel, WIDTH-bit registered stream mux with internal arbitration.
//  Each input has a valid/ready handshake; one winner per cycle is forwarded through a single output register.
//  Optional packet lock holds the grant until a beat with last=1 has transferred.
//  Sits between multiple requesters (e.g. IF/MEM ports) and one shared downstream port (memory/bus).
// PARAMETERS
//  N_IN    4   number of input channels, >=2; SELW = $clog2(N_IN) (localparam)
//  WIDTH   32  data width per channel
//  MODE    1   0 = fixed priority (lowest index wins); 1 = round-robin
//  LOCK    1   1 = hold grant from first beat until in_last beat transfers; 0 = re-arbitrate every beat
// PORTS
//  clk        in   1            single clock, all state on rising edge
//  rst        in   1            synchronous reset, active-high
//  in_data    in   N_IN*WIDTH   channel i at [i*WIDTH +: WIDTH]
//  in_valid   in   N_IN         channel i has a beat
//  in_last    in   N_IN         beat on channel i ends its packet
//  in_ready   out  N_IN         beat on channel i accepted this cycle when valid&ready
//  out_data   out  WIDTH        registered data
//  out_last   out  1            registered last flag
//  out_sel    out  SELW         index of the channel that supplied out_data
//  out_valid  out  1            output register holds a beat
//  out_ready  in   1            downstream accepts when out_valid&out_ready
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): out_valid=0, out_data=0, out_last=0, out_sel=0, ptr=0, state=ARB; overrides all other events, drops any lock/in-flight beat.
//  - can_load = !out_valid | out_ready. in_ready[i] = can_load & (i==grant) & any valid; at most one bit of in_ready high.
//  - Comb paths in_valid->in_ready and out_ready->in_ready are permitted; no path from in_data to any ready.
//  - Grant (state ARB): MODE 0 -> lowest i with in_valid[i]; MODE 1 -> first i with in_valid[i] searching ptr, ptr+1, ..., wrapping N_IN-1 -> 0.
//  - Grant (state LOCKED): grant = lock_ch regardless of other valids; other channels see in_ready=0.
//  - Transfer: in_valid[g]&in_ready[g] -> next edge out_data=in_data[g], out_last=in_last[g], out_sel=g, out_valid=1. Latency 1 cycle; throughput 1 beat/cycle under out_ready=1.
//  - No transfer & out_ready=1 & out_valid=1 -> out_valid=0 next edge. Stall (out_valid&!out_ready): out_* held stable, all in_ready=0.
//  - FSM (LOCK=1): ARB --transfer with in_last=0--> LOCKED (lock_ch=g); LOCKED --transfer with in_last=1--> ARB; otherwise stay. LOCK=0: always ARB.
//  - ptr (MODE 1 only): on transfer that returns/keeps FSM in ARB, ptr = (g==N_IN-1) ? 0 : g+1. Unchanged on idle cycles, stalls, and mid-packet beats.
//  - Locked channel dropping valid: stay LOCKED, no transfer, other channels keep waiting (no timeout).
//  - Simultaneous drain+load (out_valid&out_ready&transfer): new beat replaces old in same edge, out_valid stays 1.
//  - Reset mid-packet: next cycle is ARB with ptr=0; remaining beats of the broken packet arbitrate as new packets.
// TESTING
//  T1 reset: hold rst 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0 during reset; first grant after reset = ch0.
//  T2 RR fairness (MODE1,LOCK0,N_IN=4): all valid, out_ready=1, single-beat last=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
//  T3 fixed priority (MODE0): ch1,ch3 valid with data 0x11111111/0x33333333 -> ch1 wins every cycle, ch3 in_ready=0 until ch1 drops valid.
//  T4 packet lock: ch2 sends 3 beats 0xA0,0xA1,0xA2(last) while ch0 valid -> out_sel=2 for 3 beats in order, then ch3/ch0 per ptr=3 wraps to ch0.
//  T5 backpressure: out_ready=0 for 3 cycles with out_data=0xDEADBEEF -> out_* unchanged, in_ready=0; release -> next beat appears 1 cycle later, no beat lost or duplicated.
//  T6 reset mid-packet: rst during locked beat 2 of 4 -> state ARB, out_valid=0; random traffic scoreboard (10k cycles) checks order per channel, no loss.

Source files
------------

// File: rtl/stream_arb_mux_if.sv
// Stream bundle between N_IN requesters and one shared downstream port.
// The master is the side that sources input beats and sinks the output stream.
interface stream_arb_mux_if #(
   parameter int N_IN  = 4,
   parameter int WIDTH = 32
);
   localparam int SELW = $clog2(N_IN);

   logic [N_IN*WIDTH-1:0] in_data;
   logic [N_IN-1:0]       in_valid;
   logic [N_IN-1:0]       in_last;
   logic [N_IN-1:0]       in_ready;
   logic [WIDTH-1:0]      out_data;
   logic                  out_last;
   logic [SELW-1:0]       out_sel;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_last, out_sel, out_valid
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_last, out_sel, out_valid
   );
endinterface

// File: rtl/stream_arb_mux.sv
// N-channel registered stream mux with fixed-priority or round-robin arbitration
// and optional packet lock that keeps the grant until a last beat transfers.
module stream_arb_mux #(
   parameter int N_IN  = 4,
   parameter int WIDTH = 32,
   parameter int MODE  = 1,
   parameter int LOCK  = 1
) (
   input logic              clk,
   input logic              rst,
   stream_arb_mux_if.slave  bus
);
   localparam int SELW = $clog2(N_IN);

   localparam logic [0:0] ST_ARB    = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [SELW-1:0]  lockCh_q, lockCh_d;
   logic [SELW-1:0]  ptr_q, ptr_d;
   logic [WIDTH-1:0] outData_q, outData_d;
   logic             outLast_q, outLast_d;
   logic [SELW-1:0]  outSel_q, outSel_d;
   logic             outValid_q, outValid_d;

   logic [SELW-1:0]  grant;
   logic             grantValid;
   logic [SELW:0]    rrIdx;
   logic             canLoad;
   logic             transfer;

   // A locked packet owns the grant even while its channel is idle.
   always_comb begin
      grant      = '0;
      grantValid = 1'b0;
      rrIdx      = '0;
      if (LOCK != 0 && state_q == ST_LOCKED) begin
         grant      = lockCh_q;
         grantValid = bus.in_valid[lockCh_q];
      end else if (MODE == 0) begin
         for (int i = N_IN - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
               grant      = SELW'(i);
               grantValid = 1'b1;
            end
         end
      end else begin
         for (int k = 0; k < N_IN; k++) begin
            rrIdx = {1'b0, ptr_q} + (SELW+1)'(k);
            if (rrIdx >= (SELW+1)'(N_IN)) begin
               rrIdx = rrIdx - (SELW+1)'(N_IN);
            end
            if (!grantValid && bus.in_valid[rrIdx[SELW-1:0]]) begin
               grant      = rrIdx[SELW-1:0];
               grantValid = 1'b1;
            end
         end
      end
   end

   assign canLoad  = !outValid_q || bus.out_ready;
   assign transfer = !rst && canLoad && grantValid;

   always_comb begin
      bus.in_ready = '0;
      if (transfer) begin
         bus.in_ready[grant] = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      lockCh_d   = lockCh_q;
      ptr_d      = ptr_q;
      outData_d  = outData_q;
      outLast_d  = outLast_q;
      outSel_d   = outSel_q;
      outValid_d = outValid_q;
      if (transfer) begin
         outData_d  = bus.in_data[grant*WIDTH +: WIDTH];
         outLast_d  = bus.in_last[grant];
         outSel_d   = grant;
         outValid_d = 1'b1;
         if (LOCK != 0) begin
            if (bus.in_last[grant]) begin
               state_d = ST_ARB;
            end else begin
               state_d  = ST_LOCKED;
               lockCh_d = grant;
            end
         end
         // Pointer only advances once a packet is complete.
         if (MODE != 0 && (LOCK == 0 || bus.in_last[grant])) begin
            ptr_d = (grant == SELW'(N_IN - 1)) ? '0 : grant + SELW'(1);
         end
      end else if (bus.out_ready) begin
         outValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_ARB;
         lockCh_q   <= '0;
         ptr_q      <= '0;
         outData_q  <= '0;
         outLast_q  <= 1'b0;
         outSel_q   <= '0;
         outValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lockCh_q   <= lockCh_d;
         ptr_q      <= ptr_d;
         outData_q  <= outData_d;
         outLast_q  <= outLast_d;
         outSel_q   <= outSel_d;
         outValid_q <= outValid_d;
      end
   end

   assign bus.out_data  = outData_q;
   assign bus.out_last  = outLast_q;
   assign bus.out_sel   = outSel_q;
   assign bus.out_valid = outValid_q;
endmodule
